// File: rtl/chess_move_detector_if.sv
// Bus between the chess layout matrix / display side and the move detector.
// The master drives the board snapshot and history pops. The slave (detector)
// returns move events, turn/count, and the move-history FIFO head and status.
interface chess_move_detector_if #(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 8,
  parameter int COUNT_WIDTH   = 8
);
  localparam int MATRIX_WIDTH = CHESS_SQUARES * SQUARE_WIDTH;

  logic [MATRIX_WIDTH-1:0] Layout;
  logic                    HistRdEn;
  logic                    MoveValid;
  logic                    MoveError;
  logic [5:0]              MoveSrc;
  logic [5:0]              MoveDst;
  logic [3:0]              MovePiece;
  logic [3:0]              CapturedPiece;
  logic                    Turn;
  logic [COUNT_WIDTH-1:0]  MoveCount;
  logic [11:0]             HistRdData;
  logic                    HistEmpty;
  logic                    HistFull;
  logic                    HistOverflow;

  modport master (
    output Layout, HistRdEn,
    input  MoveValid, MoveError, MoveSrc, MoveDst, MovePiece, CapturedPiece,
           Turn, MoveCount, HistRdData, HistEmpty, HistFull, HistOverflow
  );

  modport slave (
    input  Layout, HistRdEn,
    output MoveValid, MoveError, MoveSrc, MoveDst, MovePiece, CapturedPiece,
           Turn, MoveCount, HistRdData, HistEmpty, HistFull, HistOverflow
  );
endinterface

// File: rtl/chess_move_detector.sv
// Turns successive board snapshots into move/error pulses.
// It tracks the side to move and the move count, and logs {src,dst} of each
// valid move in a first-word-fall-through history FIFO. When the FIFO is full,
// the FIFO drops its oldest entry.
module chess_move_detector #(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 8,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH,
  parameter int HIST_DEPTH    = 16,
  parameter int COUNT_WIDTH   = 8
) (
  input logic                 OutClock,
  input logic                 resetApp,
  chess_move_detector_if.slave bus
);
  localparam int                PTR_W     = $clog2(HIST_DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    DEPTH_C   = HIST_DEPTH[PTR_W:0];
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [MATRIX_WIDTH-1:0] layout_s;
  logic [3:0]              cur_s  [CHESS_SQUARES];
  logic [3:0]              prev_q [CHESS_SQUARES];
  logic                    primed_q;
  logic                    unused_flags_s;

  logic [1:0] diff_cnt_s;
  logic [5:0] first_s, last_s, src_s, dst_s;
  logic       any_s, pair_ok_s, valid_s, error_s;

  logic                   move_valid_q, move_error_q, turn_q, turn_d;
  logic [5:0]             src_q, src_d, dst_q, dst_d;
  logic [3:0]             piece_q, piece_d, cap_q, cap_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [11:0]    hist_mem_q [HIST_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_s;
  logic           push_s, pop_s, drop_s;
  logic [11:0]    push_data_s, rd_data_q, rd_data_d;
  logic           empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;

  assign layout_s = bus.Layout;
  // Only the colour and piece bits are compared.
  // Cursor/lock flags are deliberately ignored, so they are folded into a sink.
  assign unused_flags_s = ^layout_s;

  // Extract the {colour, piece} nibble of every square.
  always_comb begin
    for (int i = 0; i < CHESS_SQUARES; i++) begin
      cur_s[i] = layout_s[i*SQUARE_WIDTH +: 4];
    end
  end

  // Snapshot register: the first edge after reset primes, and every later edge refreshes.
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      primed_q <= 1'b0;
      for (int i = 0; i < CHESS_SQUARES; i++) prev_q[i] <= 4'd0;
    end else begin
      primed_q <= 1'b1;
      prev_q   <= cur_s;
    end
  end

  // Count the squares that differ, saturating at 3.
  // Also record the first and last differing square.
  always_comb begin
    diff_cnt_s = 2'd0;
    first_s    = 6'd0;
    last_s     = 6'd0;
    any_s      = 1'b0;
    for (int i = 0; i < CHESS_SQUARES; i++) begin
      if (cur_s[i] != prev_q[i]) begin
        if (!any_s) first_s = 6'(i);
        else        first_s = first_s;
        any_s  = 1'b1;
        last_s = 6'(i);
        if (diff_cnt_s != 2'd3) diff_cnt_s = diff_cnt_s + 2'd1;
        else                    diff_cnt_s = diff_cnt_s;
      end else begin
        any_s = any_s;
      end
    end
  end

  // Classify a two-square change.
  // It is a move when one square emptied and the other now holds that piece.
  always_comb begin
    pair_ok_s = 1'b0;
    src_s     = first_s;
    dst_s     = last_s;
    if (diff_cnt_s == 2'd2) begin
      if (cur_s[first_s] == 4'd0 && prev_q[first_s] != 4'd0 &&
          cur_s[last_s] == prev_q[first_s]) begin
        pair_ok_s = 1'b1;
      end else if (cur_s[last_s] == 4'd0 && prev_q[last_s] != 4'd0 &&
                   cur_s[first_s] == prev_q[last_s]) begin
        pair_ok_s = 1'b1;
        src_s     = last_s;
        dst_s     = first_s;
      end else begin
        pair_ok_s = 1'b0;
      end
    end else begin
      pair_ok_s = 1'b0;
    end
  end

  assign valid_s = primed_q && pair_ok_s && (prev_q[src_s][3] == turn_q);
  assign error_s = primed_q && any_s && !valid_s;

  // Next values for the move record, the turn and the counter.
  // These advance only on a valid move.
  always_comb begin
    if (valid_s) begin
      src_d   = src_s;
      dst_d   = dst_s;
      piece_d = prev_q[src_s];
      cap_d   = prev_q[dst_s];
      turn_d  = ~turn_q;
      count_d = count_q + CNT_ONE;
    end else begin
      src_d   = src_q;
      dst_d   = dst_q;
      piece_d = piece_q;
      cap_d   = cap_q;
      turn_d  = turn_q;
      count_d = count_q;
    end
  end

  // Register the event pulses and the move record.
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      move_valid_q <= 1'b0;
      move_error_q <= 1'b0;
      src_q        <= 6'd0;
      dst_q        <= 6'd0;
      piece_q      <= 4'd0;
      cap_q        <= 4'd0;
      turn_q       <= 1'b1;
      count_q      <= '0;
    end else begin
      move_valid_q <= valid_s;
      move_error_q <= error_s;
      src_q        <= src_d;
      dst_q        <= dst_d;
      piece_q      <= piece_d;
      cap_q        <= cap_d;
      turn_q       <= turn_d;
      count_q      <= count_d;
    end
  end

  // FIFO next state.
  // A push into a full FIFO without a pop overwrites the oldest slot, because
  // there wr and rd share an index; the read pointer then advances past it.
  always_comb begin
    pop_s       = bus.HistRdEn && !empty_q;
    push_s      = valid_s;
    push_data_s = {src_s, dst_s};
    drop_s      = push_s && full_q && !pop_s;
    if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else        wr_ptr_d = wr_ptr_q;
    if (pop_s || drop_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
    else                 rd_ptr_d = rd_ptr_q;
    occ_s   = wr_ptr_d - rd_ptr_d;
    empty_d = (occ_s == '0);
    full_d  = (occ_s == DEPTH_C);
    ovf_d   = ovf_q | drop_s;
    if (push_s && (rd_ptr_d[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0])) begin
      rd_data_d = push_data_s;
    end else begin
      rd_data_d = hist_mem_q[rd_ptr_d[PTR_W-1:0]];
    end
  end

  // History storage write port; the storage holds no reset state.
  always_ff @(posedge OutClock) begin
    if (push_s) hist_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_s;
    else        hist_mem_q[wr_ptr_q[PTR_W-1:0]] <= hist_mem_q[wr_ptr_q[PTR_W-1:0]];
  end

  // FIFO pointers, status flags and the registered head entry.
  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= 12'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.MoveValid     = move_valid_q;
  assign bus.MoveError     = move_error_q;
  assign bus.MoveSrc       = src_q;
  assign bus.MoveDst       = dst_q;
  assign bus.MovePiece     = piece_q;
  assign bus.CapturedPiece = cap_q;
  assign bus.Turn          = turn_q;
  assign bus.MoveCount     = count_q;
  assign bus.HistRdData    = rd_data_q;
  assign bus.HistEmpty     = empty_q;
  assign bus.HistFull      = full_q;
  assign bus.HistOverflow  = ovf_q;
endmodule

// File: tb/tb_chess_move_detector.sv
// Directed bench for chess_move_detector.
// A small board model predicts each edge's outcome into a scoreboard queue,
// and the DUT outputs are compared against it after the edge.
module tb_chess_move_detector;
  logic OutClock = 1'b0;
  logic resetApp;
  always #5 OutClock = ~OutClock;

  chess_move_detector_if bus ();
  chess_move_detector dut (.OutClock(OutClock), .resetApp(resetApp), .bus(bus));

  typedef struct {
    logic v; logic e; logic [5:0] src; logic [5:0] dst;
    logic [3:0] piece; logic [3:0] cap; logic turn; logic [7:0] cnt;
    logic empty; logic full; logic ovf; logic hv; logic [11:0] head;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [7:0]  board [64];
  logic [3:0]  m_prev [64];
  bit          m_primed, m_turn, m_ovf;
  logic [7:0]  m_cnt;
  logic [5:0]  m_src, m_dst;
  logic [3:0]  m_piece, m_cap;
  logic [11:0] hist_q [$];
  exp_t        exp_q [$];
  int          wpos, bpos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_primed = 1'b0; m_turn = 1'b1; m_ovf = 1'b0; m_cnt = 8'd0;
    m_src = 6'd0; m_dst = 6'd0; m_piece = 4'd0; m_cap = 4'd0;
    hist_q.delete();
    exp_q.delete();
  endtask

  // Reference behaviour for one clock edge; pushes the expectation.
  task automatic predict(input bit pop);
    int n, a, b, s, d;
    logic v, e;
    exp_t x;
    n = 0; a = -1; b = -1; s = -1; d = 0; v = 1'b0; e = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (board[i][3:0] !== m_prev[i]) begin
        n++;
        if (a < 0) a = i; else b = i;
      end
    end
    if (!m_primed) begin
      m_primed = 1'b1;
    end else if (n == 2) begin
      if (board[a][3:0] == 4'd0 && m_prev[a] != 4'd0 && board[b][3:0] == m_prev[a]) begin
        s = a; d = b;
      end else if (board[b][3:0] == 4'd0 && m_prev[b] != 4'd0 && board[a][3:0] == m_prev[b]) begin
        s = b; d = a;
      end
      if (s >= 0 && m_prev[s][3] == m_turn) v = 1'b1; else e = 1'b1;
    end else if (n != 0) begin
      e = 1'b1;
    end
    if (pop && hist_q.size() > 0) void'(hist_q.pop_front());
    if (v) begin
      m_src = 6'(s); m_dst = 6'(d); m_piece = m_prev[s]; m_cap = m_prev[d];
      m_turn = ~m_turn; m_cnt = m_cnt + 8'd1;
      if (hist_q.size() == 16) begin
        void'(hist_q.pop_front());
        m_ovf = 1'b1;
      end
      hist_q.push_back({6'(s), 6'(d)});
    end
    for (int i = 0; i < 64; i++) m_prev[i] = board[i][3:0];
    x.v = v; x.e = e; x.src = m_src; x.dst = m_dst; x.piece = m_piece; x.cap = m_cap;
    x.turn = m_turn; x.cnt = m_cnt; x.empty = (hist_q.size() == 0);
    x.full = (hist_q.size() == 16); x.ovf = m_ovf; x.hv = (hist_q.size() > 0);
    x.head = (hist_q.size() > 0) ? hist_q[0] : 12'd0;
    exp_q.push_back(x);
  endtask

  // Present the board, run one edge, then score the DUT against the queue head.
  task automatic cyc(input bit pop);
    exp_t x;
    for (int i = 0; i < 64; i++) bus.Layout[i*8 +: 8] = board[i];
    bus.HistRdEn = pop;
    predict(pop);
    @(posedge OutClock);
    #1;
    bus.HistRdEn = 1'b0;
    x = exp_q.pop_front();
    chk("MoveValid", 32'(bus.MoveValid), 32'(x.v));
    chk("MoveError", 32'(bus.MoveError), 32'(x.e));
    chk("MoveSrc", 32'(bus.MoveSrc), 32'(x.src));
    chk("MoveDst", 32'(bus.MoveDst), 32'(x.dst));
    chk("MovePiece", 32'(bus.MovePiece), 32'(x.piece));
    chk("CapturedPiece", 32'(bus.CapturedPiece), 32'(x.cap));
    chk("Turn", 32'(bus.Turn), 32'(x.turn));
    chk("MoveCount", 32'(bus.MoveCount), 32'(x.cnt));
    chk("HistEmpty", 32'(bus.HistEmpty), 32'(x.empty));
    chk("HistFull", 32'(bus.HistFull), 32'(x.full));
    chk("HistOverflow", 32'(bus.HistOverflow), 32'(x.ovf));
    if (x.hv) chk("HistRdData", 32'(bus.HistRdData), 32'(x.head));
  endtask

  // Assert reset away from the clock edge and check that outputs clear at once.
  task automatic do_reset();
    resetApp = 1'b1;
    model_reset();
    #1;
    chk("rst_MoveValid", 32'(bus.MoveValid), 32'd0);
    chk("rst_MoveError", 32'(bus.MoveError), 32'd0);
    chk("rst_MoveSrc", 32'(bus.MoveSrc), 32'd0);
    chk("rst_MoveDst", 32'(bus.MoveDst), 32'd0);
    chk("rst_MovePiece", 32'(bus.MovePiece), 32'd0);
    chk("rst_CapturedPiece", 32'(bus.CapturedPiece), 32'd0);
    chk("rst_Turn", 32'(bus.Turn), 32'd1);
    chk("rst_MoveCount", 32'(bus.MoveCount), 32'd0);
    chk("rst_HistRdData", 32'(bus.HistRdData), 32'd0);
    chk("rst_HistEmpty", 32'(bus.HistEmpty), 32'd1);
    chk("rst_HistFull", 32'(bus.HistFull), 32'd0);
    chk("rst_HistOverflow", 32'(bus.HistOverflow), 32'd0);
    @(posedge OutClock);
    #1;
    resetApp = 1'b0;
  endtask

  task automatic init_board();
    for (int i = 0; i < 64; i++) board[i] = 8'h00;
    board[52] = 8'h09; board[12] = 8'h01; board[1] = 8'h02; board[6] = 8'h02;
    board[57] = 8'h0A; board[4] = 8'h06; board[60] = 8'h0E; board[0] = 8'h04;
  endtask

  task automatic rook_board();
    for (int i = 0; i < 64; i++) board[i] = 8'h00;
    board[0] = 8'h0C; board[56] = 8'h04;
    wpos = 0; bpos = 56;
  endtask

  // White rook walks rank 0 and black rook walks rank 7, each one file at a time.
  task automatic rook_move(input bit pop);
    int nxt;
    if (m_turn) begin
      nxt = (wpos + 1) % 8;
      board[nxt] = board[wpos]; board[wpos] = 8'h00; wpos = nxt;
    end else begin
      nxt = 56 + ((bpos - 56 + 1) % 8);
      board[nxt] = board[bpos]; board[bpos] = 8'h00; bpos = nxt;
    end
    cyc(pop);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Layout = '0;
    bus.HistRdEn = 1'b0;
    resetApp = 1'b0;
    for (int i = 0; i < 64; i++) m_prev[i] = 4'd0;
    init_board();
    do_reset();

    // Priming edge plus static board: no pulses.
    repeat (3) cyc(1'b0);

    // White pawn 52 -> 44.
    board[52] = 8'h00; board[44] = 8'h09;
    cyc(1'b0);
    chk("pawn_hist_head", 32'(bus.HistRdData), 32'h0000_0D2C);
    chk("pawn_valid", 32'(bus.MoveValid), 32'd1);
    repeat (5) cyc(1'b0);

    // Black pawn 12 captures on 44.
    board[12] = 8'h00; board[44] = 8'h01;
    cyc(1'b0);
    chk("capture_piece", 32'(bus.CapturedPiece), 32'd9);

    // Black knight moves while white is to move.
    board[1] = 8'h00; board[18] = 8'h02;
    cyc(1'b0);
    chk("wrong_colour_error", 32'(bus.MoveError), 32'd1);

    // Three squares change at once.
    board[57] = 8'h00; board[42] = 8'h0A; board[4] = 8'h00;
    cyc(1'b0);

    // Only cursor/lock flags change.
    board[60][7:4] = 4'h5; board[18][7:4] = 4'hA;
    cyc(1'b0);

    // A piece vanishes.
    board[6] = 8'h00;
    cyc(1'b0);

    // White king 60 -> 59; the source still carries flag bits.
    board[60] = 8'h00; board[59] = 8'h0E;
    cyc(1'b0);

    // Fill the FIFO exactly, then push and pop together while full, then overflow.
    do_reset();
    rook_board();
    cyc(1'b0);
    repeat (16) rook_move(1'b0);
    chk("full_at_16", 32'(bus.HistFull), 32'd1);
    rook_move(1'b1);
    chk("no_ovf_push_pop", 32'(bus.HistOverflow), 32'd0);
    rook_move(1'b0);
    chk("ovf_on_drop", 32'(bus.HistOverflow), 32'd1);
    repeat (17) cyc(1'b1);
    chk("drained_empty", 32'(bus.HistEmpty), 32'd1);

    // Seventeen moves without reads: the head is move 2 (black 56 -> 57).
    do_reset();
    rook_board();
    cyc(1'b0);
    repeat (17) rook_move(1'b0);
    chk("head_is_move2", 32'(bus.HistRdData), 32'(12'({6'd56, 6'd57})));
    cyc(1'b1);

    // Reset while MoveValid is high; the next edge only primes.
    do_reset();
    init_board();
    cyc(1'b0);
    board[52] = 8'h00; board[44] = 8'h09;
    cyc(1'b0);
    do_reset();
    init_board();
    board[50] = 8'h09;
    cyc(1'b0);
    chk("prime_no_event", 32'({bus.MoveValid, bus.MoveError}), 32'd0);
    board[50] = 8'h00; board[42] = 8'h09;
    cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
